// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants, the symbolic instruction-kind enum and encoder error codes.
// Opcode/funct values match the control decoder so both sides agree on the instruction set.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Codes 24..31 are unknown kinds.
    typedef enum logic [4:0] {
        K_ADD  = 5'd0,  K_ADDU  = 5'd1,  K_SUB   = 5'd2,  K_SUBU = 5'd3,
        K_AND  = 5'd4,  K_OR    = 5'd5,  K_XOR   = 5'd6,  K_NOR  = 5'd7,
        K_SLT  = 5'd8,  K_SLTU  = 5'd9,  K_ADDI  = 5'd10, K_ADDIU = 5'd11,
        K_SLTI = 5'd12, K_SLTIU = 5'd13, K_ANDI  = 5'd14, K_ORI  = 5'd15,
        K_XORI = 5'd16, K_LUI   = 5'd17, K_LW    = 5'd18, K_SW   = 5'd19,
        K_BEQ  = 5'd20, K_BNE   = 5'd21, K_J     = 5'd22, K_JAL  = 5'd23
    } instr_kind_t;

    localparam logic [1:0] ERR_KIND     = 2'd0;
    localparam logic [1:0] ERR_BRANCH   = 2'd1;
    localparam logic [1:0] ERR_JUMP     = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Request and output streams of the instruction encoder.
// slave is the encoder side; master is the requester / memory-loader side.
interface mips_instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_kind;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [15:0] req_imm;
    logic [31:0] req_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_word;

    modport slave (
        input  req_valid, req_kind, req_rs, req_rt, req_rd, req_imm, req_target, out_ready,
        output req_ready, out_valid, out_addr, out_word
    );

    modport master (
        output req_valid, req_kind, req_rs, req_rt, req_rd, req_imm, req_target, out_ready,
        input  req_ready, out_valid, out_addr, out_word
    );
endinterface

// File: rtl/mips_instr_pack.sv
// Combinational packer: one symbolic request at a given pc -> 32-bit MIPS word,
// or an error code when the kind is unknown or a branch/jump target is unreachable.
module mips_instr_pack
    import mips_isa_pkg::*;
(
    input  logic [4:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [31:0] target,
    input  logic [31:0] pc,
    output logic [31:0] word,
    output logic        err,
    output logic [1:0]  err_code
);
    logic [31:0]        pc4;
    logic signed [32:0] diff;
    logic signed [32:0] off;
    logic               br_ok;
    logic               j_ok;

    // 33-bit signed difference so that any pair of 32-bit addresses is exact.
    always_comb begin
        pc4   = pc + 32'd4;
        diff  = $signed({1'b0, target}) - $signed({1'b0, pc4});
        off   = diff >>> 2;
        br_ok = (target[1:0] == 2'b00) && ((off[32:15] == '0) || (off[32:15] == '1));
        j_ok  = (target[1:0] == 2'b00) && (target[31:28] == pc4[31:28]);
    end

    always_comb begin
        word     = '0;
        err      = 1'b0;
        err_code = ERR_KIND;
        case (kind)
            K_ADD:   word = enc_r(rs, rt, rd, FN_ADD);
            K_ADDU:  word = enc_r(rs, rt, rd, FN_ADDU);
            K_SUB:   word = enc_r(rs, rt, rd, FN_SUB);
            K_SUBU:  word = enc_r(rs, rt, rd, FN_SUBU);
            K_AND:   word = enc_r(rs, rt, rd, FN_AND);
            K_OR:    word = enc_r(rs, rt, rd, FN_OR);
            K_XOR:   word = enc_r(rs, rt, rd, FN_XOR);
            K_NOR:   word = enc_r(rs, rt, rd, FN_NOR);
            K_SLT:   word = enc_r(rs, rt, rd, FN_SLT);
            K_SLTU:  word = enc_r(rs, rt, rd, FN_SLTU);
            K_ADDI:  word = enc_i(OP_ADDI, rs, rt, imm);
            K_ADDIU: word = enc_i(OP_ADDIU, rs, rt, imm);
            K_SLTI:  word = enc_i(OP_SLTI, rs, rt, imm);
            K_SLTIU: word = enc_i(OP_SLTIU, rs, rt, imm);
            K_ANDI:  word = enc_i(OP_ANDI, rs, rt, imm);
            K_ORI:   word = enc_i(OP_ORI, rs, rt, imm);
            K_XORI:  word = enc_i(OP_XORI, rs, rt, imm);
            K_LUI:   word = enc_i(OP_LUI, 5'd0, rt, imm);
            K_LW:    word = enc_i(OP_LW, rs, rt, imm);
            K_SW:    word = enc_i(OP_SW, rs, rt, imm);
            K_BEQ, K_BNE: begin
                word = enc_i((kind == K_BEQ) ? OP_BEQ : OP_BNE, rs, rt, off[15:0]);
                if (!br_ok) begin
                    err      = 1'b1;
                    err_code = ERR_BRANCH;
                end
            end
            K_J, K_JAL: begin
                word = {(kind == K_J) ? OP_J : OP_JAL, target[27:2]};
                if (!j_ok) begin
                    err      = 1'b1;
                    err_code = ERR_JUMP;
                end
            end
            default: begin
                err      = 1'b1;
                err_code = ERR_KIND;
            end
        endcase
    end
endmodule

// File: rtl/mips_instr_encoder.sv
// Sequential MIPS program builder: accepts symbolic requests and streams {addr, word}
// pairs at a running PC, with overflow and encoding errors latched until the next start.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int unsigned MAX_WORDS = 1024,
    localparam int unsigned WCW      = $clog2(MAX_WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  finish,
    mips_instr_encoder_if.slave   bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [WCW-1:0]        word_count
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state, state_n;
    logic        finish_pending, finish_pending_n;
    logic [31:0] pc;
    logic        out_valid;
    logic [31:0] out_addr, out_word;
    logic        req_ready, accept, overflow, acc_err, emit;
    logic [1:0]  acc_code;
    logic [31:0] pack_word;
    logic        pack_err;
    logic [1:0]  pack_code;

    mips_instr_pack u_pack (
        .kind     (bus.req_kind),
        .rs       (bus.req_rs),
        .rt       (bus.req_rt),
        .rd       (bus.req_rd),
        .imm      (bus.req_imm),
        .target   (bus.req_target),
        .pc       (pc),
        .word     (pack_word),
        .err      (pack_err),
        .err_code (pack_code)
    );

    // Capacity overflow outranks any encoding error of the same request.
    always_comb begin
        req_ready = (state == S_RUN) && !finish_pending && (!out_valid || bus.out_ready);
        accept    = bus.req_valid && req_ready;
        overflow  = (word_count == WCW'(MAX_WORDS));
        acc_err   = accept && (overflow || pack_err);
        acc_code  = overflow ? ERR_OVERFLOW : pack_code;
        emit      = accept && !acc_err;
    end

    always_comb begin
        state_n          = state;
        finish_pending_n = finish_pending;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n          = S_RUN;
                    finish_pending_n = 1'b0;
                end
            end
            S_RUN: begin
                if (acc_err) begin
                    state_n          = S_DONE;
                    finish_pending_n = 1'b0;
                end else if (finish || finish_pending) begin
                    // Wait for the last word (including one accepted right now) to drain.
                    if (emit || (out_valid && !bus.out_ready)) begin
                        finish_pending_n = 1'b1;
                    end else begin
                        state_n          = S_DONE;
                        finish_pending_n = 1'b0;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            finish_pending <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            err_code       <= '0;
            word_count     <= '0;
            pc             <= BASE_ADDR;
            out_valid      <= 1'b0;
            out_addr       <= '0;
            out_word       <= '0;
        end else begin
            finish_pending <= finish_pending_n;
            busy           <= (state_n == S_RUN);
            done           <= (state_n == S_DONE);
            if ((state != S_RUN) && start) begin
                pc         <= BASE_ADDR;
                word_count <= '0;
                err        <= 1'b0;
                err_code   <= '0;
            end
            if (emit) begin
                pc         <= pc + 32'd4;
                word_count <= word_count + 1'b1;
            end
            if (acc_err && !err) begin
                err      <= 1'b1;
                err_code <= acc_code;
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_addr  <= pc;
                out_word  <= pack_word;
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_addr  = out_addr;
    assign bus.out_word  = out_word;
endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Sequential MIPS instruction encoder, the inverse of the control decoder. It accepts symbolic instruction requests (kind plus register, immediate and target fields) over a valid/ready port. It packs each request into a 32-bit MIPS word at a running PC and streams `{addr, word}` pairs to the instruction-memory loader, so that testbenches and the boot loader can build programs in hardware. It supports exactly the decoder's instruction set.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_3000: PC of the first emitted word; must be word-aligned.
- `MAX_WORDS`, default 1024: capacity; the word after the last is an overflow error.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a program; honoured in IDLE or DONE.
- `finish` in 1: end the program; honoured in RUN.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_kind` in 5: instruction kind (enum in package).
- `req_rs`, `req_rt`, `req_rd` in 5 each: register fields.
- `req_imm` in 16: immediate field.
- `req_target` in 32: absolute byte target for BEQ/BNE/J/JAL.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_addr` out 32: PC of `out_word`.
- `out_word` out 32: encoded instruction.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `err` out 1: sticky error flag.
- `err_code` out 2: code of the first error.
- `word_count` out clog2(MAX_WORDS+1): number of words emitted.

## Operation
- States are IDLE, RUN and DONE. Reset goes to IDLE.
  - IDLE or DONE, `start` → RUN: pc=BASE_ADDR, word_count=0, err=0, err_code=0.
  - RUN, `finish` with no output pending → DONE. If output is pending, DONE is entered in the cycle after the final `out_ready` handshake.
  - RUN, error detected → DONE.
- Request acceptance: `req_ready = (state==RUN) && !finish_pending && (!out_valid || out_ready)`. A request is accepted when `req_valid && req_ready`.
- Encoding uses standard MIPS fields:
  - R-type (ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU): `{6'h00, rs, rt, rd, 5'h0, funct}`. Funct codes are 0x20–0x27, 0x2A and 0x2B.
  - I-type (ADDI 0x08, ADDIU 0x09, SLTI 0x0A, SLTIU 0x0B, ANDI 0x0C, ORI 0x0D, XORI 0x0E, LUI 0x0F, LW 0x23, SW 0x2B): `{op, rs, rt, imm}`. LUI forces rs=0.
  - BEQ 0x04 and BNE 0x05: `off = (target - (pc+4)) >>> 2`, and `imm = off[15:0]`.
  - J 0x02 and JAL 0x03: `{op, target[27:2]}`.
- Error codes. The first error is latched into `err_code`, `err` goes high, no word is emitted, and the request is still consumed.
  - 0: unknown `req_kind`.
  - 1: branch target misaligned, or offset outside −32768..32767 (computed in 33-bit signed arithmetic).
  - 2: jump target misaligned, or `target[31:28] != (pc+4)[31:28]`.
  - 3: an accepted request while word_count==MAX_WORDS.
- On a valid encoding: pc += 4 and word_count += 1, both at acceptance. pc wraps modulo 2^32 with no error.
- `start` in RUN and `finish` outside RUN are ignored. If `start` and `finish` are asserted together in RUN, `finish` wins.
- `rst` mid-program aborts it immediately. Any pending output is discarded.

## Timing
- Reset values: state=IDLE, `req_ready`=0, `out_valid`=0, `out_addr`=0, `out_word`=0, `busy`=0, `done`=0, `err`=0, `err_code`=0, `word_count`=0.
- Latency: a request accepted in cycle N produces `out_valid` in cycle N+1, from registered outputs.
- Throughput is 1 word/cycle while `out_ready`=1.
- While `out_valid && !out_ready`, `out_addr` and `out_word` hold stable.
- An error is visible on `err` and `done` in cycle N+1.
- `busy` and `done` are registered state decodes.

## Structure
- `mips_isa_pkg` holds:
  - opcode and funct constants, shared with the decoder;
  - the `instr_kind_t` enum (5-bit; values 0–23 cover the supported set, everything else is unknown);
  - the error-code constants.
- One combinational sub-module, `mips_instr_pack`: inputs are kind, fields, target and pc; outputs are word, err and err_code. The FSM, counters and output register stay in the top.

## Test plan
- ADDU: reset, `start`, ADDU rs=1 rt=2 rd=3 → `out_word`=0x00221821 at `out_addr`=0x3000; `word_count`=1.
- ORI: ORI rs=0 rt=8 imm=0x1234 as the second request → 0x34081234 at 0x3004.
- Branch: BEQ rs=1 rt=2 target=0x3000 issued at pc 0x3008 → 0x1022FFFD. BNE at pc 0x300C with target 0x3002 → `err`=1, `err_code`=1, `done`=1, no output.
- JAL: at pc 0x3000 with target 0x3010 → 0x0C000C04. J with target 0x1000_0000 at pc 0x3000 → `err_code`=2.
- Backpressure: hold `out_ready`=0 for 3 cycles with `req_valid`=1 → `req_ready`=0 and `out_word`/`out_addr` stable. Release → words emitted in order, none lost.
- Overflow and reset: with MAX_WORDS=2, a third valid request → `err_code`=3. Then assert `rst` mid-RUN with `out_valid`=1 → the next cycle shows all reset values and state IDLE.
